multi_channel_quantizer: RTL and testbench
==========================================

Name: multi_channel_quantizer

Overview:
Streaming JPEG quantizer that replaces the per-component matrix quantizers with one parametrised block serving NUM_CH components (Y/Cb/Cr). It accepts one DCT coefficient per cycle over a valid/ready handshake and selects the per-channel table at each block start. Each coefficient is multiplied by a precomputed reciprocal (2^SHIFT/Q), then shifted, rounded and saturated. It sits between the DCT stage and the zigzag/entropy stage.

Parameters:
IN_W, 11, signed input coefficient width
OUT_W, 11, signed output width; results saturate to this width
NUM_CH, 3, number of quantization tables/channels
SHIFT, 12, reciprocal fixed-point shift; RECIP = floor(2^SHIFT / Q)
Q_TABLES, '{default:1}, int [NUM_CH][64] quantization steps (1..255), raster index k = 8*row+col

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  input coefficient valid
in_ready  out  1  block can accept input this cycle
in_data  in  IN_W  signed coefficient
in_first  in  1  marks coefficient 0 of a block
in_ch  in  $clog2(NUM_CH)  channel select, sampled only with in_first
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
out_data  out  OUT_W  quantized coefficient
out_idx  out  6  coefficient index 0..63
out_ch  out  $clog2(NUM_CH)  channel of this coefficient
out_first  out  1  high with out_idx==0
out_last  out  1  high with out_idx==63
err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset (rst low, async): all valids 0, out_data/out_idx/out_ch 0, first/last 0, err 0, index counter 0, latched channel 0. A partially received block is discarded; the next block restarts at idx 0.
- Reciprocal table RECIP[c][k] computed at elaboration; unsigned, SHIFT+1 bits (Q=1 -> 4096).
- Handshake: transfer when valid&&ready on each side. advance = !out_valid || out_ready; in_ready = advance. The whole pipeline stalls when advance=0; registered outputs are held stable.
- Pipeline: S1 registers the signed product in_data*RECIP[ch][idx] (IN_W+SHIFT+2 bits) with tags. S2 applies round/shift and saturation, then drives the outputs. Latency is 2 cycles from input accept to out_valid with no stall. Throughput is 1 coefficient per cycle.
- Index counter: increments on each accepted input and wraps 63->0. Channel is latched on an accepted in_first and held for the block.
- Shift: the operation is applied to the magnitude, and the sign is restored afterwards (symmetric about zero).
- Saturation: clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Protocol errors (err pulses 1 cycle after the accepting edge):
  - in_first when counter!=0: the current block is abandoned, the counter restarts with this coefficient as idx 0, and the new channel is latched.
  - No in_first when counter==0: the coefficient is processed as idx 0 using the previously latched channel.
  - in_ch>=NUM_CH with in_first: channel 0 is used.
- Simultaneous out accept and in accept: both occur in the same cycle with no bubble.

Optional Feature:
QUANT_ROUND_EN
- Defined: round half away from zero; add 2^(SHIFT-1) to the magnitude before the shift.
- Undefined: truncate toward zero (magnitude shifted only).
- Latency is identical in both builds.

Test Plan:
1. Q all 1, ch0, inputs -32..31 with in_first on the first, out_ready=1 -> out_data equals input, out_valid 2 cycles after the first accept, out_first on idx 0, out_last on the 64th output.
2. Q_TABLES[2] all 16, block on ch2, inputs 200, -200, 24, 7:
   - QUANT_ROUND_EN defined -> 13, -13, 2, 0.
   - Undefined -> 12, -12, 1, 0.
3. out_ready low for 5 cycles at idx 20 with in_valid held high -> in_ready low during the stall, out_data/out_idx stable, all 64 outputs delivered in order with no loss or duplication.
4. in_first asserted at counter 10 with in_ch=1 -> err pulse, that coefficient emitted as idx 0 ch1, following coefficients at idx 1, 2, …
5. OUT_W=8, Q=1, inputs 200 and -1024 -> 127 and -128. Default OUT_W=11, input -1024 -> -1024.
6. rst low at idx 30 mid-block -> out_valid/err 0 immediately (asynchronous). After release, a new block with in_first starts at idx 0 with correct channel and outputs.

Source files
------------

// File: rtl/multi_channel_quantizer.sv
// Streaming JPEG quantizer: one coefficient per cycle, per-channel reciprocal tables, 2-stage pipeline.
// Build macro QUANT_ROUND_EN selects round-half-away-from-zero; otherwise results truncate toward zero.
module multi_channel_quantizer #(
    parameter int IN_W   = 11,
    parameter int OUT_W  = 11,
    parameter int NUM_CH = 3,
    parameter int SHIFT  = 12,
    parameter int Q_TABLES [NUM_CH][64] = '{default: '{default: 1}},
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_first,
    input  logic [CH_W-1:0]         in_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [5:0]              out_idx,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_first,
    output logic                    out_last,
    output logic                    err
);

    localparam int PW = IN_W + SHIFT + 2;
    localparam int QW = PW - SHIFT;
    localparam int MW = ((QW > OUT_W) ? QW : OUT_W) + 1;
    localparam int RW = SHIFT + 1;
    localparam logic [MW-1:0] POS_LIM = MW'((1 << (OUT_W - 1)) - 1);
    localparam logic [MW-1:0] NEG_LIM = MW'(1 << (OUT_W - 1));

    // Reciprocals are elaboration-time constants, so this array folds into a ROM.
    logic [RW-1:0] recip [NUM_CH][64];
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar k = 0; k < 64; k++) begin : g_k
            assign recip[c][k] = RW'((64'd1 << SHIFT) / 64'(Q_TABLES[c][k]));
        end
    end

    logic advance, accept;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;

    logic [5:0]           cnt;
    logic [CH_W-1:0]      ch_lat;
    logic [5:0]           idx_eff;
    logic [CH_W-1:0]      ch_eff;
    logic                 ch_bad;
    logic                 proto_err;
    logic signed [PW-1:0] prod;

    always_comb begin
        ch_bad    = int'(in_ch) >= NUM_CH;
        idx_eff   = in_first ? 6'd0 : cnt;
        ch_eff    = !in_first ? ch_lat : (ch_bad ? '0 : in_ch);
        proto_err = (in_first && (cnt != 6'd0 || ch_bad)) || (!in_first && cnt == 6'd0);
    end

    assign prod = PW'(in_data) * $signed(PW'(recip[ch_eff][idx_eff]));

    logic                 s1_valid;
    logic signed [PW-1:0] s1_prod;
    logic [5:0]           s1_idx;
    logic [CH_W-1:0]      s1_ch;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            ch_lat   <= '0;
            err      <= 1'b0;
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_idx   <= '0;
            s1_ch    <= '0;
        end else begin
            err <= accept && proto_err;
            if (advance) begin
                s1_valid <= accept;
                if (accept) begin
                    cnt     <= idx_eff + 6'd1;
                    ch_lat  <= ch_eff;
                    s1_prod <= prod;
                    s1_idx  <= idx_eff;
                    s1_ch   <= ch_eff;
                end
            end
        end
    end

    logic                    neg;
    logic [PW-1:0]           mag;
    logic [MW-1:0]           q;
    logic signed [OUT_W-1:0] sat;

    // Shift the magnitude so truncation and rounding are symmetric about zero.
    always_comb begin
        neg = s1_prod[PW-1];
        mag = neg ? $unsigned(-s1_prod) : $unsigned(s1_prod);
`ifdef QUANT_ROUND_EN
        mag = mag + (PW'(1) << (SHIFT - 1));
`endif
        q = MW'(mag >> SHIFT);
        if (!neg) begin
            sat = (q > POS_LIM) ? OUT_W'(POS_LIM) : OUT_W'(q);
        end else begin
            sat = (q > NEG_LIM) ? OUT_W'(NEG_LIM) : OUT_W'(-q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_ch    <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            out_first <= s1_valid && (s1_idx == 6'd0);
            out_last  <= s1_valid && (s1_idx == 6'd63);
            if (s1_valid) begin
                out_data <= sat;
                out_idx  <= s1_idx;
                out_ch   <= s1_ch;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_quantizer.sv
// Self-checking bench for multi_channel_quantizer: arithmetic reference model plus scoreboard,
// with directed vectors for latency, rounding, stall, protocol errors, saturation and reset.
module tb_multi_channel_quantizer;

    localparam int NCH = 3;
    localparam int QT [NCH][64] = '{
        '{default: 1},
        '{ 1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15, 16,
          17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31, 32,
          33, 34, 35, 36, 37, 38, 39, 40, 41, 42, 43, 44, 45, 46, 47, 48,
          49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 60, 61, 62, 63, 64},
        '{default: 16}
    };

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic               out_ready = 1'b1;
    logic signed [10:0] in_data = '0;
    logic [1:0]         in_ch = '0;
    logic               in_ready, out_valid, out_first, out_last, err;
    logic signed [10:0] out_data;
    logic [5:0]         out_idx;
    logic [1:0]         out_ch;

    logic               in_ready8, out_valid8, out_first8, out_last8, err8;
    logic signed [7:0]  out_data8;
    logic [5:0]         out_idx8;
    logic [1:0]         out_ch8;

    multi_channel_quantizer #(.IN_W(11), .OUT_W(11), .NUM_CH(NCH), .SHIFT(12), .Q_TABLES(QT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_first(in_first), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_ch(out_ch), .out_first(out_first),
        .out_last(out_last), .err(err)
    );

    multi_channel_quantizer #(.IN_W(11), .OUT_W(8), .NUM_CH(NCH), .SHIFT(12)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .in_first(in_first), .in_ch(in_ch), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_idx(out_idx8), .out_ch(out_ch8), .out_first(out_first8),
        .out_last(out_last8), .err(err8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference quantizer written from the arithmetic definition.
    function automatic int quant(input int x, input int qstep, input int ow);
        int r, mag, m, v, hi, lo;
        r   = 4096 / qstep;
        mag = ((x < 0) ? -x : x) * r;
`ifdef QUANT_ROUND_EN
        mag = mag + 2048;
`endif
        m  = mag / 4096;
        v  = (x < 0) ? -m : m;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    typedef struct {
        int data;
        int idx;
        int ch;
    } exp_t;

    exp_t sb[$];
    int   got[$];
    int   got8[$];
    int   m_cnt = 0;
    int   m_ch = 0;
    bit   err_pend = 0;
    int   err_seen = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    bit                 stall_prev = 0;
    logic signed [10:0] prev_data;
    logic [5:0]         prev_idx;

    always @(negedge clk) begin : monitor
        exp_t e;
        bit   bad_ch;
        int   idx;
        if (!rst) begin
            sb.delete();
            m_cnt      = 0;
            m_ch       = 0;
            err_pend   = 0;
            stall_prev = 0;
        end else begin
            check("err", err, err_pend);
            if (err) err_seen++;
            check("in_ready", in_ready, !out_valid || out_ready);
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_idx", out_idx, prev_idx);
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;

            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_out: got idx %0d data %0d, expected none", out_idx, out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_idx", out_idx, e.idx);
                    check("out_ch", out_ch, e.ch);
                    check("out_first", out_first, e.idx == 0);
                    check("out_last", out_last, e.idx == 63);
                    got.push_back(int'(out_data));
                end
            end
            if (out_valid8 && out_ready) got8.push_back(int'(out_data8));

            err_pend = 0;
            if (in_valid && in_ready) begin
                bad_ch   = in_first && (in_ch >= NCH);
                err_pend = (in_first && (m_cnt != 0 || bad_ch)) || (!in_first && m_cnt == 0);
                idx      = in_first ? 0 : m_cnt;
                if (in_first) m_ch = bad_ch ? 0 : int'(in_ch);
                e.data = quant(int'(in_data), QT[m_ch][idx], 11);
                e.idx  = idx;
                e.ch   = m_ch;
                sb.push_back(e);
                m_cnt = (idx + 1) % 64;
            end
        end
    end

    task automatic send(input int d, input bit f = 0, input int c = 0);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = 11'(d);
        in_first = f;
        in_ch    = 2'(c);
        do begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", n);
                $fatal(1, "send bound expired");
            end
        end while (!in_ready);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic block_rest(input int n, input int seed);
        for (int i = 0; i < n; i++) send(((i * 37 + seed) % 2001) - 1000);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin : stim
        int c0, e0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_first_last", {out_first, out_last}, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: identity on ch0, 2-cycle latency, full-rate streaming
        got.delete();
        send(-32, 1, 0);
        check("lat_early_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat2_valid", out_valid, 1);
        check("lat2_data", out_data, -32);
        check("lat2_first", out_first, 1);
        c0 = cyc;
        for (int i = -31; i <= 31; i++) send(i);
        check("throughput_cycles", cyc - c0, 63);
        drain();
        check("t1_count", got.size(), 64);
        check("t1_first_val", got[0], -32);
        check("t1_last_val", got[63], 31);

        // 2: ch2 with Q=16 rounding/truncation
        got.delete();
        send(200, 1, 2);
        send(-200);
        send(24);
        send(7);
        block_rest(60, 11);
        drain();
`ifdef QUANT_ROUND_EN
        check("t2_v0", got[0], 13);
        check("t2_v1", got[1], -13);
        check("t2_v2", got[2], 2);
        check("t2_v3", got[3], 0);
`else
        check("t2_v0", got[0], 12);
        check("t2_v1", got[1], -12);
        check("t2_v2", got[2], 1);
        check("t2_v3", got[3], 0);
`endif

        // 3: output stall while input stays valid, ch1 varying Q
        got.delete();
        fork
            begin
                send(-500, 1, 1);
                block_rest(63, 500);
            end
            begin
                int n;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!(out_valid && out_idx == 6'd20 && out_ch == 2'd1) && n < 300);
                check("t3_reached_idx20", out_idx, 20);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                check("t3_stall_in_ready", in_ready, 0);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("t3_count", got.size(), 64);

        // 4: protocol errors
        e0 = err_seen;
        send(10, 1, 0);
        block_rest(9, 3);
        send(77, 1, 1);
        block_rest(63, 7);
        send(50, 0, 0);
        block_rest(63, 9);
        send(100, 1, 3);
        block_rest(63, 13);
        drain();
        check("t4_err_count", err_seen - e0, 3);

        // 5: saturation on the narrow-output instance, full range on the default one
        got.delete();
        got8.delete();
        send(200, 1, 0);
        send(-1024);
        block_rest(62, 17);
        drain();
        check("t5_sat_pos", got8[0], 127);
        check("t5_sat_neg", got8[1], -128);
        check("t5_wide_pos", got[0], 200);
        check("t5_wide_neg", got[1], -1024);

        // 6: asynchronous reset mid-block
        send(5, 1, 2);
        block_rest(29, 19);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_err", err, 0);
        check("t6_async_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        got.delete();
        send(100, 1, 1);
        block_rest(63, 23);
        drain();
        check("t6_count", got.size(), 64);
        check("t6_first_val", got[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
